// File: rtl/ccff_chain_loader.sv
// Serial loader for the fabric CCFF configuration chain: bitstream words in, one bit per prog_clk shift out.
// Optional readback compare during a re-stream pass is enabled with `define CCFF_VERIFY_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 11
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              prog_en,
  input  logic              ccff_tail,
`ifdef CCFF_VERIFY_EN
  input  logic              verify,
  output logic              err,
  output logic [15:0]       err_cnt,
`endif
  output logic              busy,
  output logic              done
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0]  WORD_CNT = BC_W'(WORD_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W:0]   LEN_X    = (CNT_W + 1)'(CHAIN_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [CNT_W-1:0]   bit_cnt_nxt_s;
  logic [WORD_W-1:0]  buf_r;
  logic [WORD_W-1:0]  buf_nxt_s;
  logic [BC_W-1:0]    buf_cnt_r;
  logic [BC_W-1:0]    buf_cnt_nxt_s;
  logic               head_r;
  logic               head_nxt_s;
  logic               en_r;
  logic               en_nxt_s;
  logic               ready_r;
  logic               ready_nxt_s;
  logic               busy_r;
  logic               done_r;
  logic               accept_s;

  assign word_ready = ready_r;
  assign ccff_head  = head_r;
  assign prog_en    = en_r;
  assign busy       = busy_r;
  assign done       = done_r;

  // Next-state decisions for the coming edge: which bit (if any) is issued and what the buffer keeps
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    buf_nxt_s     = buf_r;
    buf_cnt_nxt_s = buf_cnt_r;
    head_nxt_s    = head_r;
    en_nxt_s      = 1'b0;
    accept_s      = ready_r & word_valid;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s   = ST_SHIFT;
          bit_cnt_nxt_s = '0;
          buf_nxt_s     = '0;
          buf_cnt_nxt_s = '0;
        end else begin
          state_nxt_s   = state_r;
        end
      end
      ST_SHIFT: begin
        if (buf_cnt_r != '0) begin
          en_nxt_s   = 1'b1;
          head_nxt_s = buf_r[0];
          // Ready is only offered with one bit left, so a new word replaces the buffer whole
          if (accept_s) begin
            buf_nxt_s     = word_data;
            buf_cnt_nxt_s = WORD_CNT;
          end else begin
            buf_nxt_s     = buf_r >> 1'b1;
            buf_cnt_nxt_s = buf_cnt_r - 1'b1;
          end
        end else if (accept_s) begin
          en_nxt_s      = 1'b1;
          head_nxt_s    = word_data[0];
          buf_nxt_s     = word_data >> 1'b1;
          buf_cnt_nxt_s = WORD_CNT - 1'b1;
        end else begin
          en_nxt_s      = 1'b0;
          head_nxt_s    = head_r;
        end
        if (en_nxt_s) begin
          bit_cnt_nxt_s = bit_cnt_r + 1'b1;
          if (bit_cnt_r == LAST_IDX) begin
            state_nxt_s   = ST_DONE;
            buf_cnt_nxt_s = '0;
          end else begin
            state_nxt_s   = ST_SHIFT;
          end
        end else begin
          bit_cnt_nxt_s = bit_cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    ready_nxt_s = (state_nxt_s == ST_SHIFT) && (buf_cnt_nxt_s <= BC_W'(1)) &&
                  (({1'b0, bit_cnt_nxt_s} + (CNT_W + 1)'(buf_cnt_nxt_s)) < LEN_X);
  end

  // Control and datapath registers; reset aborts a pass on the same edge
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      buf_r     <= '0;
      buf_cnt_r <= '0;
      head_r    <= 1'b0;
      en_r      <= 1'b0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      buf_r     <= buf_nxt_s;
      buf_cnt_r <= buf_cnt_nxt_s;
      head_r    <= head_nxt_s;
      en_r      <= en_nxt_s;
      ready_r   <= ready_nxt_s;
      busy_r    <= (state_nxt_s == ST_SHIFT);
      done_r    <= (state_nxt_s == ST_DONE);
    end
  end

`ifdef CCFF_VERIFY_EN
  logic        verify_r;
  logic        err_r;
  logic [15:0] err_cnt_r;

  assign err     = err_r;
  assign err_cnt = err_cnt_r;

  // Readback compare: on each shift edge the tail still carries the previous pass's bit of that index
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      verify_r  <= 1'b0;
      err_r     <= 1'b0;
      err_cnt_r <= 16'h0000;
    end else if (start && (state_r != ST_SHIFT)) begin
      verify_r  <= verify;
      err_r     <= 1'b0;
      err_cnt_r <= 16'h0000;
    end else if (verify_r && en_r && (ccff_tail != head_r)) begin
      err_r <= 1'b1;
      if (err_cnt_r != 16'hFFFF) begin
        err_cnt_r <= err_cnt_r + 16'h0001;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end else begin
      err_r     <= err_r;
      err_cnt_r <= err_cnt_r;
    end
  end
`else
  logic unused_tail_s;
  assign unused_tail_s = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (16-bit and 12-bit chains) checked every cycle
// against a bit-queue model of the bitstream plus a behavioural shift-register chain.
module tb_ccff_chain_loader;

  localparam int S_ID = 0;
  localparam int S_SH = 1;
  localparam int S_DN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, st, wv, rdy, head, pen, tail, busy, done;
  logic [7:0]  wd [2];
  logic [15:0] chain0 = 16'h0000;
  logic [15:0] chain1 = 16'h0000;
  assign tail[0] = chain0[15];
  assign tail[1] = chain1[11];

`ifdef CCFF_VERIFY_EN
  logic [1:0]  vf, err;
  logic [15:0] ecnt0, ecnt1;
`endif

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(5)) u0 (
    .prog_clk(clk), .pReset(rst[0]), .start(st[0]), .word_valid(wv[0]), .word_data(wd[0]),
    .word_ready(rdy[0]), .ccff_head(head[0]), .prog_en(pen[0]), .ccff_tail(tail[0]),
`ifdef CCFF_VERIFY_EN
    .verify(vf[0]), .err(err[0]), .err_cnt(ecnt0),
`endif
    .busy(busy[0]), .done(done[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(4)) u1 (
    .prog_clk(clk), .pReset(rst[1]), .start(st[1]), .word_valid(wv[1]), .word_data(wd[1]),
    .word_ready(rdy[1]), .ccff_head(head[1]), .prog_en(pen[1]), .ccff_tail(tail[1]),
`ifdef CCFF_VERIFY_EN
    .verify(vf[1]), .err(err[1]), .err_cnt(ecnt1),
`endif
    .busy(busy[1]), .done(done[1])
  );

  int          ntests = 0;
  int          nfail  = 0;
  int          cyc    = 0;
  int          mst [2];
  int          miss [2];
  int          macc [2];
  int          first_en [2];
  int          last_en [2];
  int          mstall [2];
  logic [31:0] ms [2];
  logic        mlast [2];
  logic        armed [2];
  logic        acc [2];

  function automatic int len(input int i);
    return (i == 0) ? 16 : 12;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model step: check this cycle's outputs, then account for what the coming edge does
  task automatic check_cycle();
    logic avail;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      acc[i] = 1'b0;
      if (armed[i]) begin
        avail = (mst[i] == S_SH) && (macc[i] > miss[i]);
        chk($sformatf("prog_en%0d", i), int'(pen[i]), int'(avail));
        if (pen[i] && avail) begin
          if (miss[i] == 0) first_en[i] = cyc;
          chk($sformatf("head%0d", i), int'(head[i]), int'(ms[i][miss[i]]));
          mlast[i] = ms[i][miss[i]];
          miss[i]++;
          if (miss[i] == len(i)) begin
            mst[i]     = S_DN;
            last_en[i] = cyc;
          end
        end else if (!pen[i]) begin
          if (mst[i] == S_SH && miss[i] > 0) mstall[i]++;
          chk($sformatf("head_hold%0d", i), int'(head[i]), int'(mlast[i]));
        end
        chk($sformatf("busy%0d", i), int'(busy[i]), int'(mst[i] == S_SH));
        chk($sformatf("done%0d", i), int'(done[i]), int'(mst[i] == S_DN));
        chk($sformatf("ready%0d", i), int'(rdy[i]),
            int'(mst[i] == S_SH && (macc[i] - miss[i]) <= 1 && macc[i] < len(i)));
      end
      if (rst[i]) begin
        armed[i] = 1'b1;
        mst[i]   = S_ID;
        miss[i]  = 0;
        macc[i]  = 0;
        mlast[i] = 1'b0;
      end else if (st[i] && mst[i] != S_SH) begin
        mst[i]      = S_SH;
        miss[i]     = 0;
        macc[i]     = 0;
        ms[i]       = 32'h0;
        mstall[i]   = 0;
        first_en[i] = 0;
        last_en[i]  = 0;
      end else if (mst[i] == S_SH && wv[i] && rdy[i]) begin
        ms[i][macc[i] +: 8] = wd[i];
        macc[i] += 8;
        acc[i]   = 1'b1;
      end
    end
  endtask

  task automatic tick();
    logic [1:0] pe, hd;
    @(negedge clk);
    pe = pen;
    hd = head;
    check_cycle();
    @(posedge clk);
    #1;
    if (pe[0]) chain0 = {chain0[14:0], hd[0]};
    if (pe[1]) chain1 = {chain1[14:0], hd[1]};
  endtask

  task automatic pulse_start(input int i);
    st[i] = 1'b1;
    tick();
    st[i] = 1'b0;
  endtask

  task automatic push_word(input int i, input logic [7:0] d);
    int n;
    n = 0;
    wv[i] = 1'b1;
    wd[i] = d;
    tick();
    while (!acc[i] && n < 100) begin
      tick();
      n++;
    end
    chk($sformatf("accept%0d", i), int'(acc[i]), 1);
    wv[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (!done[i] && n < 300) begin
      tick();
      n++;
    end
    chk($sformatf("done_reached%0d", i), int'(done[i]), 1);
    tick();
    tick();
  endtask

  initial begin
    rst   = 2'b11;
    st    = 2'b00;
    wv    = 2'b00;
    wd[0] = 8'h00;
    wd[1] = 8'h00;
`ifdef CCFF_VERIFY_EN
    vf    = 2'b00;
`endif
    for (int i = 0; i < 2; i++) begin
      armed[i] = 1'b0; mst[i] = S_ID; miss[i] = 0; macc[i] = 0; ms[i] = 32'h0;
      mlast[i] = 1'b0; acc[i] = 1'b0; mstall[i] = 0; first_en[i] = 0; last_en[i] = 0;
    end
    tick();
    tick();
    rst = 2'b00;
    tick();
    chk("rst_prog_en", int'(pen[0]), 0);
    chk("rst_ready", int'(rdy[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_head", int'(head[0]), 0);

    // 1: two back-to-back words into the 16-bit chain
    pulse_start(0);
    push_word(0, 8'hA5);
    push_word(0, 8'h3C);
    wait_done(0);
    chk("t1_chain", int'(chain0), 32'hA53C);
    chk("t1_shifts", miss[0], 16);
    chk("t1_span", last_en[0] - first_en[0] + 1, 16);
    chk("t1_stall", mstall[0], 0);

    // 2: 12-bit chain drops the top nibble of the second word
    pulse_start(1);
    push_word(1, 8'hA5);
    push_word(1, 8'h3C);
    chk("t2_ready_after2", int'(rdy[1]), 0);
    wait_done(1);
    chk("t2_chain", int'(chain1[11:0]), 32'hA53);
    chk("t2_span", last_en[1] - first_en[1] + 1, 12);
    chk("t2_done", int'(done[1]), 1);

    // 3: host gap long enough to drain the buffer produces a 3-cycle stall
    pulse_start(0);
    push_word(0, 8'hA5);
    for (int k = 0; k < 10; k++) tick();
    push_word(0, 8'h3C);
    wait_done(0);
    chk("t3_stall", mstall[0], 3);
    chk("t3_span", last_en[0] - first_en[0] + 1, 19);
    chk("t3_chain", int'(chain0), 32'hA53C);

    // 4: reset during the pass, then a clean reload
    chain0 = 16'h0000;
    pulse_start(0);
    push_word(0, 8'h5A);
    begin
      int n;
      n = 0;
      while (miss[0] < 5 && n < 50) begin
        tick();
        n++;
      end
    end
    chk("t4_at_shift5", miss[0], 5);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("t4_prog_en", int'(pen[0]), 0);
    chk("t4_busy", int'(busy[0]), 0);
    chk("t4_done", int'(done[0]), 0);
    pulse_start(0);
    push_word(0, 8'hA5);
    push_word(0, 8'h3C);
    wait_done(0);
    chk("t4_chain", int'(chain0), 32'hA53C);

    // 5: start in SHIFT is ignored; start in DONE begins a new pass
    pulse_start(0);
    push_word(0, 8'hA5);
    pulse_start(0);
    push_word(0, 8'h3C);
    wait_done(0);
    chk("t5_shifts", miss[0], 16);
    chk("t5_span", last_en[0] - first_en[0] + 1, 16);
    pulse_start(0);
    chk("t5_restart_busy", int'(busy[0]), 1);
    push_word(0, 8'h0F);
    push_word(0, 8'hF0);
    wait_done(0);
    chk("t5_chain", int'(chain0), 32'hF00F);

`ifdef CCFF_VERIFY_EN
    // 6: verify pass with identical stream, then with bit 0 flipped
    vf[0] = 1'b1;
    pulse_start(0);
    vf[0] = 1'b0;
    push_word(0, 8'h0F);
    push_word(0, 8'hF0);
    wait_done(0);
    chk("t6_err_clean", int'(err[0]), 0);
    chk("t6_cnt_clean", int'(ecnt0), 0);
    chk("t6_chain_same", int'(chain0), 32'hF00F);
    vf[0] = 1'b1;
    pulse_start(0);
    vf[0] = 1'b0;
    push_word(0, 8'h0E);
    push_word(0, 8'hF0);
    wait_done(0);
    chk("t6_err_flip", int'(err[0]), 1);
    chk("t6_cnt_flip", int'(ecnt0), 1);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
